spi_xfer_ctrl: RTL

Sequencer for one SPI character transfer. On a `go` request it latches the divider and character length, then raises busy and issues a one-cycle first-edge pulse. It divides `pclk` into SCLK toggle enables and classifies each enable as a leading or trailing edge. After the final trailing edge it issues the busy-clear pulse. It sits between the SPI control registers and the shift-register/edge logic, and is the only source of `go_bsy`, `transfer`, `en_tgl`, `even` and `bsy_clr`.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_clk_div.sv | 35 +++
 rtl/spi_xfer_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and default widths for the SPI transfer sequencer.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    XFER,
    DONE
  } xfer_state_t;

  localparam int DEF_DIV_W = 16;
  localparam int DEF_CNT_W = 7;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK divider: latches the half-period on load and issues one-cycle toggle enables while run is high.
module spi_clk_div #(
  parameter int DIV_W = 16
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] divider,
  output logic             en_tgl
);

  logic [DIV_W-1:0] div_l;
  logic [DIV_W-1:0] div_cnt;

  always_comb begin
    en_tgl = run && (div_cnt == div_l);
  end

  // Counter sits at zero outside run, so every XFER entry starts a fresh half-period.
  always_ff @(posedge pclk) begin
    if (preset) begin
      div_l   <= '0;
      div_cnt <= '0;
    end else begin
      if (load)
        div_l <= divider;
      if (!run || en_tgl)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI character transfer sequencer: FSM, edge counter and registered SCLK around spi_clk_div.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             go,
  input  logic             abort,
  input  logic [DIV_W-1:0] divider,
  input  logic [CNT_W-1:0] char_len,
  input  logic             cpol,
  output logic             go_bsy,
  output logic             transfer,
  output logic             first_edge,
  output logic             en_tgl,
  output logic             even,
  output logic             leading_edge,
  output logic             trailing_edge,
  output logic             bsy_clr,
  output logic             sclk
);

  xfer_state_t     state, state_next;
  logic [CNT_W-1:0] len_l;
  logic             cpol_l;
  logic [CNT_W:0]   edge_cnt;
  logic [CNT_W:0]   last_cnt;
  logic             accept;
  logic             run;
  logic             last_edge;

  assign accept = (state == IDLE) && go;
  assign run    = (state == XFER);

  spi_clk_div #(
    .DIV_W(DIV_W)
  ) u_clk_div (
    .pclk    (pclk),
    .preset  (preset),
    .run     (run),
    .load    (accept),
    .divider (divider),
    .en_tgl  (en_tgl)
  );

  // 2N-1 == {N-1, 1}; len_l of 0 wraps to 2^CNT_W-1, giving the full-length character.
  assign last_cnt  = {len_l - CNT_W'(1), 1'b1};
  assign last_edge = en_tgl && (edge_cnt == last_cnt);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (go) state_next = FIRST;
      FIRST: state_next = abort ? DONE : XFER;
      XFER:  if (abort || last_edge) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    go_bsy        = (state != IDLE);
    first_edge    = (state == FIRST);
    transfer      = (state == XFER);
    bsy_clr       = (state == DONE);
    even          = ~edge_cnt[0];
    leading_edge  = even & en_tgl;
    trailing_edge = ~even & en_tgl;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state    <= IDLE;
      len_l    <= '0;
      cpol_l   <= 1'b0;
      edge_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        len_l  <= char_len;
        cpol_l <= cpol;
      end
      if (!run)
        edge_cnt <= '0;
      else if (en_tgl)
        edge_cnt <= edge_cnt + (CNT_W+1)'(1);
    end
  end

  // Forcing from the next state keeps an abort-coincident toggle off the pin.
  always_ff @(posedge pclk) begin
    if (preset)
      sclk <= 1'b0;
    else if (state_next == FIRST)
      sclk <= cpol;
    else if (state_next == IDLE || state_next == DONE)
      sclk <= cpol_l;
    else if (en_tgl)
      sclk <= ~sclk;
  end

endmodule
